wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard sitting between the execution units and the integer register file's write port. It accepts results from the single-cycle EXU (buffered in a small FIFO) and the multi-cycle LSU over valid/ready handshakes, picks one per cycle, and drives the register file's `waddr`/`wen`/`wdata` from registers. A per-register pending mask, set at issue and cleared at commit, lets the issue stage stall on RAW hazards.

## Interface
Parameters:
- `EXU_DEPTH`, 2: EXU result FIFO entries. Must be a power of two and ≥2.
- `STARVE_MAX`, 4: consecutive cycles the EXU FIFO head may lose arbitration before it is forced through.

Ports:
- `clock` in 1: single clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `exu_valid` in 1: EXU result offered.
- `exu_ready` out 1: FIFO not full (combinational from count).
- `exu_rd` in 5: EXU destination register.
- `exu_data` in 64: EXU result.
- `lsu_valid` in 1: LSU load result offered.
- `lsu_ready` out 1: LSU accepted this cycle (combinational).
- `lsu_rd` in 5: LSU destination register.
- `lsu_data` in 64: LSU load data.
- `iss_valid` in 1: instruction issued this cycle.
- `iss_rd` in 5: its destination register.
- `waddr` out 5: to register file, registered.
- `wen` out 1: to register file, registered.
- `wdata` out 64: to register file, registered.
- `pending` out 32: bit i set means x[i] has a write in flight, registered.

## Operation
- EXU input:
  - `exu_valid && exu_ready` pushes `{rd, data}` into the FIFO.
  - `exu_ready = (count != EXU_DEPTH)`.
- Arbitration each cycle, between the LSU input and the FIFO head:
  - LSU wins by default: `lsu_ready = 1` unless a force is active.
  - A starve counter increments each cycle the FIFO is non-empty and the head is not popped. It clears on any pop or when the FIFO is empty.
  - Force: when the counter equals `STARVE_MAX`, the head pops and `lsu_ready = 0` for that cycle. The counter saturates and never exceeds `STARVE_MAX`.
  - If `lsu_valid = 0`, a non-empty FIFO pops its head.
- Commit register: the winner's `rd`/`data` load into `waddr`/`wdata`, with `wen = (rd != 0)`.
  - A winner with `rd = 0` is consumed (handshake completes, FIFO pops) but produces `wen = 0`.
  - With no winner, `wen = 0`; `waddr`/`wdata` hold their values.
- Scoreboard:
  - `iss_valid && iss_rd != 0` sets `pending[iss_rd]`.
  - `wen` clears `pending[waddr]`.
  - Set and clear of the same index on the same edge: set wins.
  - `pending[0]` is always 0.
- FIFO push and pop in the same cycle:
  - Allowed when non-empty; count is unchanged.
  - On an empty FIFO the pushed entry is not visible until the next cycle (no bypass).

## Timing
- Reset values: `wen = 0`, `waddr = 0`, `wdata = 0`, `pending = 0`, FIFO empty, starve counter 0.
  - Hence `exu_ready = 1` and `lsu_ready = 1` right after reset.
- Latency: a result accepted at edge t appears on `wen`/`waddr`/`wdata` during cycle t+1. The RF writes it at edge t+1.
  - EXU result into an empty FIFO with no LSU contention: push at t, pop at t+1, `wen` in cycle t+2.
- `pending` bit clears at the same edge the RF write lands (t+1).
- Throughput: one commit per cycle; LSU back-to-back at full rate except on forced cycles.
- Reset asserted mid-operation: all in-flight FIFO entries and pending bits are discarded immediately (asynchronous). `wen` drops without waiting for a clock edge.

## Configuration
- `WB_ARBITER_TRACE_EN`, defined: each edge with `wen = 1` emits a simulation `$display` line containing source (EXU/LSU), `waddr` and `wdata` in hex. Each forced cycle emits a starvation notice.
- Not defined: no display statements are compiled; RTL is functionally identical.

## Test plan
- Reset, then EXU pushes `rd = 5`, data `0x1234` at t with `lsu_valid = 0` → `wen = 1`, `waddr = 5`, `wdata = 0x1234` in cycle t+2; `pending[5]` clears at t+2 after being set by `iss_rd = 5` earlier.
- Simultaneous `exu_valid` (rd 3) and `lsu_valid` (rd 4, data `0xAA`) → LSU commits first (`waddr = 4`), EXU head next cycle (`waddr = 3`).
- `lsu_valid` held high for 10 cycles with the FIFO holding one entry, `STARVE_MAX = 4` → exactly one cycle with `lsu_ready = 0` after 4 losses, EXU head commits, then LSU resumes.
- Push 2 EXU results while the LSU saturates → `exu_ready = 0` on the third offer; data order is preserved on drain.
- LSU result with `rd = 0` → `lsu_ready = 1`, `wen` stays 0; `iss_valid` with `iss_rd = 0` → `pending` stays all-zero.
- `iss_rd = 7` on the same edge that `wen` commits `waddr = 7` → `pending[7] = 1` afterwards. Drop `reset` mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: LSU vs buffered EXU results onto the register-file write port,
// plus a pending-write scoreboard. Define WB_ARBITER_TRACE_EN to compile commit/starvation traces.
module wb_arbiter #(
  parameter int EXU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [4:0]  exu_rd,
  input  logic [63:0] exu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic [4:0]  waddr,
  output logic        wen,
  output logic [63:0] wdata,
  output logic [31:0] pending
);

  localparam int PTR_W = $clog2(EXU_DEPTH);
  localparam int CNT_W = $clog2(EXU_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(EXU_DEPTH);
  localparam logic [STV_W-1:0] SMAX = STV_W'(STARVE_MAX);

  logic [4:0]       fifo_rd   [EXU_DEPTH];
  logic [63:0]      fifo_data [EXU_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;
  logic             fifo_empty, force_pop, lsu_win, pop, push;
  logic [31:0]      pend_next;

  assign fifo_empty = (count == '0);
  assign force_pop  = (starve == SMAX) && !fifo_empty;
  assign lsu_ready  = !force_pop;
  assign exu_ready  = (count != FULL);
  assign lsu_win    = lsu_valid && !force_pop;
  // The FIFO head drains whenever the LSU is not taking the port.
  assign pop        = !fifo_empty && !lsu_win;
  assign push       = exu_valid && exu_ready;

  always_comb begin
    pend_next = pending;
    if (wen) pend_next[waddr] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) pend_next[iss_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < EXU_DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      starve  <= '0;
      waddr   <= '0;
      wen     <= 1'b0;
      wdata   <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= exu_rd;
        fifo_data[wr_ptr] <= exu_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (pop || fifo_empty)  starve <= '0;
      else if (starve != SMAX) starve <= starve + STV_W'(1);

      if (lsu_win) begin
        waddr <= lsu_rd;
        wdata <= lsu_data;
        wen   <= (lsu_rd != 5'd0);
      end else if (pop) begin
        waddr <= fifo_rd[rd_ptr];
        wdata <= fifo_data[rd_ptr];
        wen   <= (fifo_rd[rd_ptr] != 5'd0);
      end else begin
        wen   <= 1'b0;
      end

      pending <= pend_next;
    end
  end

`ifdef WB_ARBITER_TRACE_EN
  logic src_lsu;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                src_lsu <= 1'b0;
    else if (lsu_win || pop)   src_lsu <= lsu_win;
  end

  always @(posedge clock) begin
    if (reset && wen)
      $display("wb_arbiter: %s commit x%0h <= %h", src_lsu ? "LSU" : "EXU", waddr, wdata);
    if (reset && force_pop)
      $display("wb_arbiter: EXU head starved, forcing x%0h", fifo_rd[rd_ptr]);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, starvation/full/reset
// sequences, and random traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  exu_rd = '0, lsu_rd = '0, iss_rd = '0;
  logic [63:0] exu_data = '0, lsu_data = '0;
  logic        exu_ready, lsu_ready, wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [31:0] pending;

  wb_arbiter #(.EXU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .waddr(waddr), .wen(wen), .wdata(wdata), .pending(pending)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue of {rd,data}, starvation as a loss streak.
  logic [68:0] mq[$];
  int          m_streak;
  logic [31:0] m_pend;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    m_streak = 0;
    m_pend = '0;
    m_wen = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic bit m_forced();
    return (m_streak == SMAX) && (mq.size() > 0);
  endfunction

  task automatic model_step(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                            input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                            input logic iv, input logic [4:0] ird);
    bit lsu_takes, head_goes, accepted;
    logic [31:0] np;
    lsu_takes = lv && !m_forced();
    head_goes = (mq.size() > 0) && !lsu_takes;
    accepted  = ev && (mq.size() < DEPTH);
    np = m_pend;
    if (m_wen) np = np & ~(32'd1 << m_waddr);
    if (iv && ird != 0) np = np | (32'd1 << ird);
    np[0] = 1'b0;
    m_pend = np;
    if (head_goes || mq.size() == 0) m_streak = 0;
    else if (m_streak < SMAX) m_streak++;
    if (lsu_takes) begin
      m_waddr = lrd; m_wdata = ld; m_wen = (lrd != 0);
    end else if (head_goes) begin
      m_waddr = mq[0][68:64]; m_wdata = mq[0][63:0]; m_wen = (mq[0][68:64] != 0);
      void'(mq.pop_front());
    end else begin
      m_wen = 1'b0;
    end
    if (accepted) mq.push_back({erd, ed});
  endtask

  logic s_exu_ready, s_lsu_ready;

  // One clock cycle: drive, check readies against the model, clock, check registered outputs.
  task automatic cyc(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                     input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                     input logic iv, input logic [4:0] ird);
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird;
    #1;
    s_exu_ready = exu_ready;
    s_lsu_ready = lsu_ready;
    chk("model exu_ready", {63'd0, exu_ready}, {63'd0, mq.size() < DEPTH});
    chk("model lsu_ready", {63'd0, lsu_ready}, {63'd0, !m_forced()});
    model_step(ev, erd, ed, lv, lrd, ld, iv, ird);
    @(posedge clock);
    #1;
    chk("model wen", {63'd0, wen}, {63'd0, m_wen});
    if (m_wen) begin
      chk("model waddr", {59'd0, waddr}, {59'd0, m_waddr});
      chk("model wdata", wdata, m_wdata);
    end
    chk("model pending", {32'd0, pending}, {32'd0, m_pend});
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  typedef struct {
    logic ev; logic [4:0] erd; logic [63:0] ed;
    logic lv; logic [4:0] lrd; logic [63:0] ld;
    logic iv; logic [4:0] ird;
    logic x_er; logic x_lr; logic x_wen; logic [4:0] x_wa; logic [63:0] x_wd; logic [31:0] x_pend;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                              input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                              input logic iv, input logic [4:0] ird,
                              input logic x_er, input logic x_lr, input logic x_wen,
                              input logic [4:0] x_wa, input logic [63:0] x_wd,
                              input logic [31:0] x_pend);
    vec_t v;
    v.ev = ev; v.erd = erd; v.ed = ed; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.x_er = x_er; v.x_lr = x_lr; v.x_wen = x_wen;
    v.x_wa = x_wa; v.x_wd = x_wd; v.x_pend = x_pend;
    return v;
  endfunction

  initial begin
    int force_cnt, force_idx, exu_commits;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset wen", {63'd0, wen}, 64'd0);
    chk("reset waddr", {59'd0, waddr}, 64'd0);
    chk("reset wdata", wdata, 64'd0);
    chk("reset pending", {32'd0, pending}, 64'd0);
    chk("reset exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("reset lsu_ready", {63'd0, lsu_ready}, 64'd1);
    reset = 1'b1;

    //            ev erd   ed       lv lrd   ld      iv ird   er lr wen wa    wd       pend
    vt[0] = mk(0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  1, 5'd5, 1, 1, 0, 5'd0, 64'h0,    32'h20);
    vt[1] = mk(1, 5'd5, 64'h1234, 0, 5'd0, 64'h0,  0, 5'd0, 1, 1, 0, 5'd0, 64'h0,    32'h20);
    vt[2] = mk(0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  0, 5'd0, 1, 1, 1, 5'd5, 64'h1234, 32'h20);
    vt[3] = mk(1, 5'd3, 64'h33,   1, 5'd4, 64'hAA, 0, 5'd0, 1, 1, 1, 5'd4, 64'hAA,   32'h0);
    vt[4] = mk(0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  0, 5'd0, 1, 1, 1, 5'd3, 64'h33,   32'h0);
    vt[5] = mk(0, 5'd0, 64'h0,    1, 5'd0, 64'h55, 1, 5'd0, 1, 1, 0, 5'd0, 64'h55,   32'h0);
    vt[6] = mk(0, 5'd0, 64'h0,    1, 5'd7, 64'h77, 1, 5'd7, 1, 1, 1, 5'd7, 64'h77,   32'h80);
    vt[7] = mk(0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  1, 5'd7, 1, 1, 0, 5'd7, 64'h77,   32'h80);
    vt[8] = mk(0, 5'd0, 64'h0,    0, 5'd0, 64'h0,  0, 5'd0, 1, 1, 0, 5'd7, 64'h77,   32'h80);

    for (int i = 0; i < 9; i++) begin
      cyc(vt[i].ev, vt[i].erd, vt[i].ed, vt[i].lv, vt[i].lrd, vt[i].ld, vt[i].iv, vt[i].ird);
      chk($sformatf("vec%0d exu_ready", i), {63'd0, s_exu_ready}, {63'd0, vt[i].x_er});
      chk($sformatf("vec%0d lsu_ready", i), {63'd0, s_lsu_ready}, {63'd0, vt[i].x_lr});
      chk($sformatf("vec%0d wen", i), {63'd0, wen}, {63'd0, vt[i].x_wen});
      chk($sformatf("vec%0d waddr", i), {59'd0, waddr}, {59'd0, vt[i].x_wa});
      chk($sformatf("vec%0d wdata", i), wdata, vt[i].x_wd);
      chk($sformatf("vec%0d pending", i), {32'd0, pending}, {32'd0, vt[i].x_pend});
    end

    // LSU saturates while one EXU entry waits: one forced cycle after 4 losses.
    force_cnt = 0; force_idx = -1; exu_commits = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i == 0, 5'd9, 64'h99, 1'b1, 5'd10, 64'(i), 1'b0, 5'd0);
      if (!s_lsu_ready) begin force_cnt++; force_idx = i; end
      if (wen && waddr == 5'd9) exu_commits++;
    end
    chk("starve force count", 64'(force_cnt), 64'd1);
    chk("starve force cycle", 64'(force_idx), 64'd5);
    chk("starve exu commits", 64'(exu_commits), 64'd1);

    // Fill the FIFO under LSU pressure, then drain in order.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 5'(11 + i), 64'hB1 + 64'(i), 1'b1, 5'd20, 64'h0, 1'b0, 5'd0);
      chk($sformatf("full offer%0d exu_ready", i), {63'd0, s_exu_ready}, {63'd0, i < 2});
    end
    idle();
    chk("drain0 waddr", {59'd0, waddr}, 64'd11);
    chk("drain0 wdata", wdata, 64'hB1);
    idle();
    chk("drain1 waddr", {59'd0, waddr}, 64'd12);
    chk("drain1 wdata", wdata, 64'hB2);
    idle();
    chk("drain empty wen", {63'd0, wen}, 64'd0);

    // Asynchronous reset in the middle of traffic.
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'hEE, 1'b1, 5'd15);
    cyc(1'b1, 5'd16, 64'h16, 1'b1, 5'd14, 64'hEF, 1'b1, 5'd17);
    chk("pre-reset wen", {63'd0, wen}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset wen", {63'd0, wen}, 64'd0);
    chk("async reset waddr", {59'd0, waddr}, 64'd0);
    chk("async reset wdata", wdata, 64'd0);
    chk("async reset pending", {32'd0, pending}, 64'd0);
    chk("async reset exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("async reset lsu_ready", {63'd0, lsu_ready}, 64'd1);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle();

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
